// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file types for the writeback path.
//   RF_AW / RF_DW / RF_NREG : architectural register file geometry
//   rf_addr_t / rf_data_t   : register address / data types
//   wb_req_t                : one writeback request {addr, data}
package rf_pkg;

    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREG = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: generic NREQ-way round-robin grant logic.
//   clk, rst  : clock, asynchronous active-low reset
//   i_valid   : per-requester request vector
//   i_en      : grant enable; when low no grant is issued
//   o_grant   : one-hot (or zero) combinational grant
// The pointer names the highest-priority requester and moves to one past
// the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_sel;
    logic [SW-1:0]   w_sum;
    logic [NREQ-1:0] w_grant;
    logic            w_found;

    // Scan ptr, ptr+1, ... modulo NREQ; first valid requester wins.
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        w_sum     = '0;
        w_sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_sel = w_sum[PW-1:0];
            if (!w_found && i_valid[w_sel]) begin
                w_found        = 1'b1;
                w_grant[w_sel] = 1'b1;
                w_ptr_nxt      = (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
            end
        end
        // Reset is also a combinational gate so no grant leaks out while held.
        if (!i_en || !rst) begin
            w_grant   = '0;
            w_found   = 1'b0;
            w_ptr_nxt = r_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NREQ writeback
// requesters with round-robin arbitration and a registered write stage.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is combinational)
//   req_addr/req_data   : packed per-requester address/data, slot i at i*W
//   wb_hold             : pipeline freeze, blocks all grants
//   wr_en/wr_addr/wr_data : registered register-file write port
//   last_grant          : one-hot copy of the most recent accepted grant
// Build option: RF_WB_X0_DROP_EN -- accepted writes to register 0 are
// consumed but do not raise wr_en.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned DW   = RF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               wb_hold,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [NREQ-1:0]    last_grant
);

    logic [NREQ-1:0] w_grant;
    logic            w_en;
    logic            w_accept;
    logic            w_write;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [NREQ-1:0] r_last_grant;

    assign w_en = ~wb_hold;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_valid (req_valid),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    // Grant is one-hot, so an OR-mux selects the winning address/data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
                w_sel_data = w_sel_data | req_data[i*DW +: DW];
            end
        end
    end

    assign w_accept = |w_grant;

`ifdef RF_WB_X0_DROP_EN
    assign w_write = w_accept && (w_sel_addr != '0);
`else
    assign w_write = w_accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_last_grant <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_accept) begin
                r_wr_addr    <= w_sel_addr;
                r_wr_data    <= w_sel_data;
                r_last_grant <= w_grant;
            end
        end
    end

    assign req_ready  = w_grant;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and constrained-random bench for rf_wb_arbiter.
// Expected writes are queued when a grant is seen; a separate monitor pops
// them on the cycle the write must appear on the register-file port.
module tb_rf_wb_arbiter;

    import rf_pkg::*;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned AW    = RF_AW;
    localparam int unsigned DW    = RF_DW;
    localparam int unsigned RND_N = 1500;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic               wb_hold = 1'b0;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [NREQ-1:0]    last_grant;

    rf_wb_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wb_hold    (wb_hold),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        wb_req_t     w;
        int unsigned due;
        bit          en;
    } exp_t;

    exp_t            q[$];
    int              checks   = 0;
    int              failures = 0;
    int unsigned     cyc      = 0;
    rf_addr_t        ta[NREQ];
    rf_data_t        td[NREQ];
    logic [NREQ-1:0] exp_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic h);
        req_valid = v;
        wb_hold   = h;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = ta[i];
            req_data[i*DW +: DW] = td[i];
        end
    endtask

    // Queue the write that an accept at the coming edge must produce.
    function automatic void push(input int g);
        exp_t e;
        e.w.addr = ta[g];
        e.w.data = td[g];
        e.due    = cyc + 1;
        e.en     = 1'b1;
`ifdef RF_WB_X0_DROP_EN
        if (ta[g] == '0) e.en = 1'b0;
`endif
        q.push_back(e);
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic h, input logic [NREQ-1:0] er);
        drive(v, h);
        @(negedge clk);
        chk("last_grant", 64'(last_grant), 64'(exp_last));
        chk("req_ready", 64'(req_ready), 64'(er));
        for (int i = 0; i < NREQ; i++) begin
            if (er[i]) begin
                push(i);
                exp_last = er;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor.
    logic [AW-1:0] hold_a = '0;
    logic [DW-1:0] hold_d = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rst_wr_en", 64'(wr_en), 64'(0));
            chk("rst_wr_addr", 64'(wr_addr), 64'(0));
            chk("rst_wr_data", 64'(wr_data), 64'(0));
            hold_a = '0;
            hold_d = '0;
        end else begin
            if (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                chk("wr_due", 64'(cyc), 64'(e.due));
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("wr_en", 64'(wr_en), 64'(e.en));
                hold_a = e.w.addr;
                hold_d = e.w.data;
            end else begin
                chk("wr_en_idle", 64'(wr_en), 64'(0));
            end
            chk("wr_addr", 64'(wr_addr), 64'(hold_a));
            chk("wr_data", 64'(wr_data), 64'(hold_d));
        end
    end

    // Requester-side protocol: a pending request stays stable until accepted.
    logic [NREQ-1:0]    pv = '0;
    logic [NREQ-1:0]    pr = '0;
    logic [NREQ*AW-1:0] pa = '0;
    logic [NREQ*DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && !pr[i] &&
                    (!req_valid[i] || pa[i*AW +: AW] != req_addr[i*AW +: AW] ||
                     pd[i*DW +: DW] != req_data[i*DW +: DW])) begin
                    failures++;
                    $display("FAIL protocol: requester %0d changed before accept (cycle %0d)", i, cyc);
                end
            end
            pv = req_valid;
        end else begin
            pv = '0;
        end
        pr = req_ready;
        pa = req_addr;
        pd = req_data;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] rdy;
        int unsigned     wcnt[NREQ];
        logic            h;

        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0;
            td[i] = '0;
        end

        // Reset: ready stays low even with every requester valid.
        drive(3'b111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_last_grant", 64'(last_grant), 64'(0));
        drive(3'b000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single request, then idle.
        ta[0] = 5'd5;  td[0] = 32'hDEADBEEF;
        step(3'b001, 1'b0, 3'b001);
        step(3'b000, 1'b0, 3'b000);
        step(3'b000, 1'b0, 3'b000);

        // All valid and held; pointer starts at 1.
        ta[0] = 5'd3;  td[0] = 32'h0000_0A00;
        ta[1] = 5'd7;  td[1] = 32'h0000_0B11;
        ta[2] = 5'd31; td[2] = 32'h0000_0C22;
        step(3'b111, 1'b0, 3'b010);
        step(3'b111, 1'b0, 3'b100);
        step(3'b111, 1'b0, 3'b001);
        step(3'b111, 1'b0, 3'b010);
        step(3'b111, 1'b0, 3'b100);
        step(3'b111, 1'b0, 3'b001);

        // Three-cycle hold with requesters 1 and 2 pending; pointer is 1.
        step(3'b110, 1'b1, 3'b000);
        step(3'b110, 1'b1, 3'b000);
        step(3'b110, 1'b1, 3'b000);
        step(3'b110, 1'b0, 3'b010);
        step(3'b100, 1'b0, 3'b100);
        step(3'b000, 1'b0, 3'b000);

        // Single-cycle hold right after an accept keeps the in-flight pulse.
        step(3'b001, 1'b0, 3'b001);
        step(3'b010, 1'b1, 3'b000);
        step(3'b010, 1'b0, 3'b010);
        step(3'b000, 1'b0, 3'b000);

        // Pointer at 2 with only 0 and 1 valid: scan wraps to 0.
        step(3'b011, 1'b0, 3'b001);
        step(3'b010, 1'b0, 3'b010);
        step(3'b000, 1'b0, 3'b000);

        // Register-0 write from requester 2.
        ta[2] = 5'd0;  td[2] = 32'h0000_1234;
        step(3'b100, 1'b0, 3'b100);
        step(3'b000, 1'b0, 3'b000);
        step(3'b000, 1'b0, 3'b000);

        // Asynchronous reset while a write is on the port.
        ta[2] = 5'd17; td[2] = 32'h0000_0D33;
        step(3'b111, 1'b0, 3'b001);
        drive(3'b000, 1'b0);
        #2;
        chk("pre_rst_wr_en", 64'(wr_en), 64'(1));
        rst = 1'b0;
        q.delete();
        exp_last = '0;
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'(0));
        chk("async_rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("async_rst_wr_data", 64'(wr_data), 64'(0));
        chk("async_rst_last", 64'(last_grant), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(3'b111, 1'b0, 3'b001);
        step(3'b110, 1'b0, 3'b010);
        step(3'b100, 1'b0, 3'b100);
        step(3'b000, 1'b0, 3'b000);

        // Random traffic; the tail stops new requests and holds to drain.
        pend = '0;
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
        for (int n = 0; n < RND_N + 4 * NREQ; n++) begin
            h = 1'b0;
            if (n < RND_N) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        ta[i]   = rf_addr_t'($urandom_range(0, 31));
                        td[i]   = $urandom;
                    end
                end
                h = ($urandom_range(0, 7) == 0);
            end
            drive(pend, h);
            @(negedge clk);
            rdy = req_ready;
            chk("rnd_onehot", 64'($onehot0(rdy)), 64'(1));
            chk("rnd_only_valid", 64'(rdy & ~pend), 64'(0));
            chk("rnd_grant_any", 64'(rdy != '0), 64'(pend != '0 && !h));
            chk("rnd_last_grant", 64'(last_grant), 64'(exp_last));
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i] && pend[i]) begin
                    push(i);
                    pend[i] = 1'b0;
                    wcnt[i] = 0;
                    exp_last = rdy;
                end else if (pend[i] && !h) begin
                    wcnt[i]++;
                end
                chk("rnd_wait_bound", 64'(wcnt[i] < NREQ), 64'(1));
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_drained", 64'(pend), 64'(0));
        step(3'b000, 1'b0, 3'b000);
        step(3'b000, 1'b0, 3'b000);
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
